// File: rtl/ser_pkg.sv
// Shared types and constants for the serial bit feeder.
// Parity helper is only referenced when SER_PARITY_EN is defined.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_e;

  localparam int SER_DEFAULT_WIDTH = 4;

  // Even parity bit of a word; callers zero-extend narrower words.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-in / serial-out feeder for the 1010 detector, MSB first, zero-bubble reload.
// Optional trailing even-parity bit per word when SER_PARITY_EN is defined.
module serial_bit_feeder
  import ser_pkg::*;
#(
  parameter int   WIDTH      = SER_DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  ser_state_e       state_r, state_s;
  logic [WIDTH-1:0] sreg_r, sreg_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             x_r, x_s;
  logic             x_valid_r, x_valid_s;
  logic             word_done_r, word_done_s;
  logic             accept_s;
`ifdef SER_PARITY_EN
  logic             parity_r, parity_s;
`endif

  // word_done_r marks the final bit of a word, which is exactly when a reload is allowed
  assign din_ready = ~reset & ((state_r == IDLE) | word_done_r);
  assign accept_s  = din_valid & din_ready;

  // Next-state, shift register and counter
  always_comb begin
    state_s = state_r;
    sreg_s  = sreg_r;
    cnt_s   = cnt_r;
`ifdef SER_PARITY_EN
    parity_s = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          sreg_s  = din;
          cnt_s   = CW'(WIDTH - 1);
          state_s = SHIFT;
`ifdef SER_PARITY_EN
          parity_s = even_parity(32'(din));
`endif
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sreg_s = {sreg_r[WIDTH-2:0], 1'b0};
        cnt_s  = cnt_r - CW'(1);
        if (cnt_r == {CW{1'b0}}) begin
`ifdef SER_PARITY_EN
          state_s = PARITY;
          cnt_s   = {CW{1'b0}};
`else
          if (accept_s) begin
            sreg_s  = din;
            cnt_s   = CW'(WIDTH - 1);
            state_s = SHIFT;
          end else begin
            state_s = IDLE;
            cnt_s   = {CW{1'b0}};
          end
`endif
        end else begin
          state_s = SHIFT;
        end
      end
      PARITY: begin
`ifdef SER_PARITY_EN
        if (accept_s) begin
          sreg_s   = din;
          cnt_s    = CW'(WIDTH - 1);
          state_s  = SHIFT;
          parity_s = even_parity(32'(din));
        end else begin
          state_s = IDLE;
        end
`else
        state_s = IDLE;
`endif
      end
      default: begin
        state_s = IDLE;
        sreg_s  = {WIDTH{1'b0}};
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // Output values for the cycle after the edge, derived from next state
  always_comb begin
    x_s         = IDLE_LEVEL;
    x_valid_s   = 1'b0;
    word_done_s = 1'b0;
    case (state_s)
      IDLE: begin
        x_s       = IDLE_LEVEL;
        x_valid_s = 1'b0;
      end
      SHIFT: begin
        x_s       = sreg_s[WIDTH-1];
        x_valid_s = 1'b1;
`ifdef SER_PARITY_EN
        word_done_s = 1'b0;
`else
        word_done_s = (cnt_s == {CW{1'b0}});
`endif
      end
      PARITY: begin
`ifdef SER_PARITY_EN
        x_s         = parity_s;
        x_valid_s   = 1'b1;
        word_done_s = 1'b1;
`else
        x_s         = IDLE_LEVEL;
`endif
      end
      default: begin
        x_s = IDLE_LEVEL;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      sreg_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      x_r         <= IDLE_LEVEL;
      x_valid_r   <= 1'b0;
      word_done_r <= 1'b0;
`ifdef SER_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      sreg_r      <= sreg_s;
      cnt_r       <= cnt_s;
      x_r         <= x_s;
      x_valid_r   <= x_valid_s;
      word_done_r <= word_done_s;
`ifdef SER_PARITY_EN
      parity_r    <= parity_s;
`endif
    end
  end

  assign x         = x_r;
  assign x_valid   = x_valid_r;
  assign word_done = word_done_r;

endmodule
